// File: rtl/prog_ctr_seq.sv
`default_nettype none
// ============================================================================
// Module      : prog_ctr_seq
// Description : Program counter sequencer. Requests absolute jump targets from
//               an external lookup table (combinational index out, target in)
//               and loads them into the PC on launch and on taken branches.
//               Otherwise the PC increments once per cycle. A one-deep link
//               register supports call/return. A start/done handshake and a
//               saturating run-cycle counter are also provided.
// Ports       : Clk, Reset        - clock, synchronous active-high reset
//               start, start_idx  - launch request and entry-point LUT index
//               halt, stall       - decoder halt / PC freeze (RUN only)
//               branch_en/_idx    - taken absolute branch and its LUT index
//               link_en, ret_en   - call (save pc+1) / return to link
//               lut_idx           - combinational LUT index
//               lut_target        - combinational LUT target
//               pc                - current instruction address
//               running, done     - registered state flags
//               cycle_cnt         - RUN cycles of the last/current program
// Revision    : 1.0 - initial release
// ============================================================================
module prog_ctr_seq #(
    parameter int D  = 12,
    parameter int A  = 8,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [A-1:0]  start_idx,
    input  logic          halt,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [A-1:0]  branch_idx,
    input  logic          link_en,
    input  logic          ret_en,
    output logic [A-1:0]  lut_idx,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [D-1:0]  c_PC_ONE  = {{(D-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};

    state_t        state_q;
    logic [D-1:0]  pc_q;
    logic [D-1:0]  link_q;
    logic [CW-1:0] cnt_q;
    logic          running_q;
    logic          done_q;

    logic          launch_w;
    logic          take_branch_w;
    logic [D-1:0]  pc_inc_w;
    logic [CW-1:0] cnt_d;

    // A launch is only honoured when no program is executing.
    assign launch_w      = start && (state_q == S_IDLE || state_q == S_DONE);
    // halt and stall both outrank a branch, so the LUT is not addressed for
    // a branch that will not be taken.
    assign take_branch_w = (state_q == S_RUN) && branch_en && !halt && !stall;
    assign pc_inc_w      = pc_q + c_PC_ONE;
    assign cnt_d         = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_CNT_ONE;

    always_comb begin
        lut_idx = '0;
        if (launch_w) begin
            lut_idx = start_idx;
        end else if (take_branch_w) begin
            lut_idx = branch_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            link_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        pc_q      <= lut_target;
                        cnt_q     <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Every RUN cycle counts, including stall and halt cycles.
                    cnt_q <= cnt_d;
                    if (halt) begin
                        state_q   <= S_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (branch_en) begin
                        pc_q <= lut_target;
                        if (link_en) begin
                            link_q <= pc_inc_w;
                        end
                    end else if (ret_en) begin
                        pc_q <= link_q;
                    end else begin
                        pc_q <= pc_inc_w;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule
`default_nettype wire
